// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60 timing constants, stage records and grey lookup (VGA_TEST_PATTERN_EN adds bar fields)
package vga_pkg;

  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_FP         = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BP         = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;

  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_FP         = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BP         = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

  localparam int FB_WIDTH      = 160;
  localparam int FB_HEIGHT     = 120;
  localparam int BYTES_PER_ROW = 40;
  localparam int BPP           = 2;

  localparam logic [12:0] BASE_ADDR = 13'd0;

  // Raw timing as seen by the scanout pipeline; syncs are active low
  typedef struct packed {
    logic [6:0] row;
    logic [5:0] col;
    logic [1:0] sub;
`ifdef VGA_TEST_PATTERN_EN
    logic [1:0] bar;
`endif
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       vblank;
  } timing_t;

  typedef struct packed {
    logic [1:0] sub;
`ifdef VGA_TEST_PATTERN_EN
    logic [1:0] bar;
`endif
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       vblank;
  } stage_t;

  // 00/01/10/11 -> 0x0/0x5/0xA/0xF
  function automatic logic [3:0] grey(input logic [1:0] pix);
    return {pix, pix};
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - VRAM display read port and DAC pins (VGA_TEST_PATTERN_EN adds testPattern)
interface vga_scanout_if;
  logic [12:0] displayAddr;
  logic [7:0]  displayRdData;
  logic        hsync;
  logic        vsync;
  logic        vblank;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
`ifdef VGA_TEST_PATTERN_EN
  logic        testPattern;
`endif

  modport master (
`ifdef VGA_TEST_PATTERN_EN
    input  testPattern,
`endif
    input  displayRdData,
    output displayAddr, hsync, vsync, vblank, red, green, blue
  );

  modport slave (
`ifdef VGA_TEST_PATTERN_EN
    output testPattern,
`endif
    output displayRdData,
    input  displayAddr, hsync, vsync, vblank, red, green, blue
  );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 800x525 raster counters with raw syncs, active flag and framebuffer coordinates
module vga_timing
  import vga_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  output timing_t t
);

  logic [9:0] h;
  logic [9:0] v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h <= 10'd0;
      v <= 10'd0;
    end else if (h == H_TOTAL - 10'd1) begin
      h <= 10'd0;
      v <= (v == V_TOTAL - 10'd1) ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Each logical pixel covers a 4x4 block, so the low two bits of both counters are dropped
  always_comb begin
    t        = '0;
    t.row    = v[8:2];
    t.col    = h[9:4];
    t.sub    = h[3:2];
`ifdef VGA_TEST_PATTERN_EN
    t.bar    = h[7:6];
`endif
    t.active = (h < H_ACTIVE) && (v < V_ACTIVE);
    t.hsync  = !((h >= H_SYNC_START) && (h <= H_SYNC_END));
    t.vsync  = !((v >= V_SYNC_START) && (v <= V_SYNC_END));
    t.vblank = (v >= V_ACTIVE);
  end

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA scanout: address, delay and unpack pipeline (VGA_TEST_PATTERN_EN selects bar pattern)
module vga_scanout
  import vga_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  vga_scanout_if.master bus
);

  timing_t     t;
  logic [12:0] row_off;
  logic [12:0] addr_next;
  logic [12:0] addr_q;
  stage_t      s1;
  stage_t      s2;
  logic [1:0]  pix;
  logic [3:0]  colour;
  logic [3:0]  colour_q;
  logic        hsync_q;
  logic        vsync_q;
  logic        vblank_q;

  vga_timing u_timing (
    .clk   (clk),
    .reset (reset),
    .t     (t)
  );

  // row*40 as row*32 + row*8; peaks at 4799 so 13 bits never overflow
  always_comb begin
    row_off   = ({6'd0, t.row} << 5) + ({6'd0, t.row} << 3);
    addr_next = t.active ? (BASE_ADDR + row_off + {7'd0, t.col}) : 13'd0;
  end

  always_comb begin
    case (s2.sub)
      2'd0:    pix = bus.displayRdData[7:6];
      2'd1:    pix = bus.displayRdData[5:4];
      2'd2:    pix = bus.displayRdData[3:2];
      default: pix = bus.displayRdData[1:0];
    endcase
`ifdef VGA_TEST_PATTERN_EN
    if (bus.testPattern) pix = s2.bar;
`endif
    colour = s2.active ? grey(pix) : 4'h0;
  end

  // The VRAM read register sits between S1 and S3, so only the side-band fields travel through s2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= 13'd0;
      s1        <= '0;
      s1.hsync  <= 1'b1;
      s1.vsync  <= 1'b1;
      s2        <= '0;
      s2.hsync  <= 1'b1;
      s2.vsync  <= 1'b1;
      colour_q  <= 4'h0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      vblank_q  <= 1'b0;
    end else begin
      addr_q    <= addr_next;
      s1.sub    <= t.sub;
`ifdef VGA_TEST_PATTERN_EN
      s1.bar    <= t.bar;
`endif
      s1.active <= t.active;
      s1.hsync  <= t.hsync;
      s1.vsync  <= t.vsync;
      s1.vblank <= t.vblank;
      s2        <= s1;
      colour_q  <= colour;
      hsync_q   <= s2.hsync;
      vsync_q   <= s2.vsync;
      vblank_q  <= s2.vblank;
    end
  end

  assign bus.displayAddr = addr_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.vblank      = vblank_q;
  assign bus.red         = colour_q;
  assign bus.green       = colour_q;
  assign bus.blue        = colour_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed self-checking bench for vga_scanout with a registered VRAM model
module tb_vga_scanout;

  localparam int LOG = 4000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  vga_scanout_if vif ();

  vga_scanout dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.master)
  );

`ifdef VGA_TEST_PATTERN_EN
  initial vif.testPattern = 1'b0;
`endif

  logic [7:0] mem [0:8191];
  always @(posedge clk) vif.displayRdData <= mem[vif.displayAddr];

  int compared = 0;
  int mismatched = 0;

  logic [3:0]  red_log  [0:LOG-1];
  logic [12:0] addr_log [0:LOG-1];
  logic        hs_log   [0:LOG-1];
  logic [3:0]  grey_tab [0:3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int idx);
    int h, v;
    h = idx % 800;
    v = (idx / 800) % 525;
    if (h < 640 && v < 480) return (v / 4) * 40 + h / 16;
    return 0;
  endfunction

  function automatic logic [3:0] exp_rgb(input int idx);
    int h, v, s;
    logic [7:0] b;
    if (idx < 0) return 4'h0;
    h = idx % 800;
    v = (idx / 800) % 525;
    if (!(h < 640 && v < 480)) return 4'h0;
    b = mem[(v / 4) * 40 + h / 16];
    s = (h / 4) % 4;
    return grey_tab[(b >> (6 - 2 * s)) & 8'h03];
  endfunction

  function automatic logic exp_hs(input int idx);
    int h;
    if (idx < 0) return 1'b1;
    h = idx % 800;
    return !(h >= 656 && h <= 751);
  endfunction

  function automatic logic exp_vs(input int idx);
    int v;
    if (idx < 0) return 1'b1;
    v = (idx / 800) % 525;
    return !(v >= 490 && v <= 491);
  endfunction

  function automatic logic exp_vb(input int idx);
    if (idx < 0) return 1'b0;
    return ((idx / 800) % 525) >= 480;
  endfunction

  // k counts rising edges since reset release; address shows idx k-1, pins show idx k-3
  task automatic run(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check("addr", vif.displayAddr, exp_addr(k - 1));
      check("hsync", vif.hsync, exp_hs(k - 3));
      check("vsync", vif.vsync, exp_vs(k - 3));
      check("vblank", vif.vblank, exp_vb(k - 3));
      check("red", vif.red, exp_rgb(k - 3));
      check("green", vif.green, exp_rgb(k - 3));
      check("blue", vif.blue, exp_rgb(k - 3));
      if (k < LOG) begin
        red_log[k]  = vif.red;
        addr_log[k] = vif.displayAddr;
        hs_log[k]   = vif.hsync;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, vif.displayAddr, 13'd0);
    check({tag, "_hsync"}, vif.hsync, 1'b1);
    check({tag, "_vsync"}, vif.vsync, 1'b1);
    check({tag, "_vblank"}, vif.vblank, 1'b0);
    check({tag, "_rgb"}, {vif.red, vif.green, vif.blue}, 12'h000);
  endtask

  initial begin
    int first_low;
    int low_cnt;
    grey_tab[0] = 4'h0;
    grey_tab[1] = 4'h5;
    grey_tab[2] = 4'hA;
    grey_tab[3] = 4'hF;
    for (int i = 0; i < 8192; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
    mem[0] = 8'h1B;

    // Reset held
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Lines 0..4 with mixed bytes
    run(3300);
    check("pix_0_3", red_log[3], 4'h0);
    check("pix_4_7", red_log[7], 4'h5);
    check("pix_8_11", red_log[11], 4'hA);
    check("pix_12_15", red_log[15], 4'hF);
    check("pix_15", red_log[18], 4'hF);
    check("addr_h0", addr_log[1], 13'd0);
    check("addr_h15", addr_log[16], 13'd0);
    check("addr_h16", addr_log[17], 13'd1);
    check("addr_h639", addr_log[640], 13'd39);
    check("addr_h640", addr_log[641], 13'd0);
    check("addr_l3_end", addr_log[3040], 13'd39);
    check("addr_l4_start", addr_log[3201], 13'd40);
    first_low = -1;
    low_cnt = 0;
    for (int k = 1; k < 900; k++) if (first_low < 0 && hs_log[k] == 1'b0) first_low = k;
    for (int k = 3; k < 803; k++) if (hs_log[k] == 1'b0) low_cnt++;
    check("first_hsync_low", first_low, 659);
    check("hsync_low_width", low_cnt, 96);

    // All bytes 0xFF
    reset = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 8'hFF;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset2");
    reset = 1'b0;
    run(1900);
    check("ff_h639", red_log[642], 4'hF);
    check("ff_h640", red_log[643], 4'h0);
    check("ff_h799", red_log[802], 4'h0);
    check("ff_l1_h0", red_log[803], 4'hF);

    // Mid-frame reset at line 2, hCount 300
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("midreset_hold");
    reset = 1'b0;
    run(900);
    check("restart_h0", red_log[3], 4'hF);
    check("restart_addr16", addr_log[17], 13'd1);
    check("restart_hsync", red_log[1], 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
